// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO stream reader.
// Holds width defaults, skid depth and the read-room helper.
package fifo_pkg;

    localparam int DATASIZE_DFLT = 8;
    localparam int CNTSIZE_DFLT  = 16;
    localparam int SKID_DEPTH    = 2;

    typedef logic [1:0] occ_t;

    // True when a new read can be issued without ever exceeding the
    // skid depth, counting words held, words in flight and a pop now.
    function automatic logic room_ok(
        input occ_t occ,
        input logic infl,
        input logic pop
    );
        logic [2:0] lvl;
        lvl = {1'b0, occ} + {2'b00, infl} - {2'b00, pop};
        return lvl < 3'(SKID_DEPTH);
    endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry in-order buffer between FIFO read data and the stream.
// Ports: clk, rst (async active-low), push_i/push_data_i (capture),
// pop_i (stream transfer), occ_o (fill level), head_o/valid_o (stream).
module stream_skid_buf
    import fifo_pkg::*;
#(
    parameter int W = DATASIZE_DFLT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output occ_t         occ_o,
    output logic [W-1:0] head_o,
    output logic         valid_o
);

    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    occ_t         occ_q, occ_d;
    logic         valid_q;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        unique case ({push_i, pop_i})
            2'b10: begin
                if (occ_q == 2'd0) head_d = push_data_i;
                else               tail_d = push_data_i;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                // Level stays put; the new word lands behind the
                // survivor so order is preserved.
                if (occ_q == 2'd1) begin
                    head_d = push_data_i;
                end else begin
                    head_d = tail_q;
                    tail_d = push_data_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            occ_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            occ_q   <= occ_d;
            valid_q <= (occ_d != 2'd0);
        end
    end

    assign occ_o   = occ_q;
    assign head_o  = head_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Pulls words from a 1-cycle-latency FIFO into a valid/ready stream.
// Ports: clk, rst (async active-low), rdata/rempty/r_en (FIFO side),
// m_data/m_valid/m_ready (stream side), rd_count (words delivered).
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int DATASIZE = DATASIZE_DFLT,
    parameter int CNTSIZE  = CNTSIZE_DFLT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATASIZE-1:0] rdata,
    input  logic                rempty,
    output logic                r_en,
    output logic [DATASIZE-1:0] m_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [CNTSIZE-1:0]  rd_count
);

    localparam logic [CNTSIZE-1:0] CNT_ONE = CNTSIZE'(1);

    logic               inflight_q;
    logic               en_q;
    logic [CNTSIZE-1:0] cnt_q;
    occ_t               occ;
    logic               pop;

    assign pop = m_valid & m_ready;

    // en_q holds off reads until the first edge after reset release.
    assign r_en = rst & en_q & ~rempty
                & room_ok(occ, inflight_q, pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_q <= 1'b0;
            en_q       <= 1'b0;
            cnt_q      <= '0;
        end else begin
            inflight_q <= r_en;
            en_q       <= 1'b1;
            if (pop) cnt_q <= cnt_q + CNT_ONE;
        end
    end

    assign rd_count = cnt_q;

    stream_skid_buf #(
        .W (DATASIZE)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .push_i      (inflight_q),
        .push_data_i (rdata),
        .pop_i       (pop),
        .occ_o       (occ),
        .head_o      (m_data),
        .valid_o     (m_valid)
    );

endmodule

// File: doc/fifo_stream_reader.md
FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 The block SHALL have parameter DATASIZE, default 8, giving the data word width in bits.
REQ-002 The block SHALL have parameter CNTSIZE, default 16, giving the delivered-word counter width in bits.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, as decided.
REQ-004 The block SHALL have port clk, input, 1 bit: rising-edge clock shared with the FIFO.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous active-low reset (0 = reset).
REQ-006 The block SHALL have port rdata, input, DATASIZE bits: FIFO read data, valid one cycle after an accepted r_en.
REQ-007 The block SHALL have port rempty, input, 1 bit: FIFO empty flag.
REQ-008 The block SHALL have port r_en, output, 1 bit: FIFO read request.
REQ-009 The block SHALL have port m_data, output, DATASIZE bits: stream data to the consumer.
REQ-010 The block SHALL have port m_valid, output, 1 bit: m_data holds a valid word.
REQ-011 The block SHALL have port m_ready, input, 1 bit: consumer accepts a word.
REQ-012 The block SHALL have port rd_count, output, CNTSIZE bits: number of words delivered.

Function
REQ-013 A 2-entry in-order buffer SHALL hold FIFO words until the stream accepts them; occ (0..2) is its fill level.
REQ-014 A register inflight SHALL equal r_en from the previous cycle.
REQ-015 r_en SHALL be asserted when rempty==0 and occ + inflight - pop < 2, where pop = m_valid && m_ready. There SHALL be no combinational path from m_ready to r_en other than through this term.
REQ-016 When inflight==1, rdata SHALL be written into the buffer tail on that rising edge.
REQ-017 m_valid SHALL equal (occ != 0), and m_data SHALL equal the head entry; both SHALL come from registers.
REQ-018 A transfer occurs on a rising edge with m_valid && m_ready. The head SHALL advance and rd_count SHALL increment by 1, wrapping from 2^CNTSIZE-1 to 0.
REQ-019 A simultaneous capture and pop SHALL leave occ unchanged and preserve word order.
REQ-020 Latency SHALL be 2 cycles: r_en is high in cycle N, rdata is captured at the end of N+1, and m_valid is high in N+2.
REQ-021 With m_ready held at 1 and the FIFO non-empty, throughput SHALL be one word per cycle.
REQ-022 While m_valid==1 and m_ready==0, m_data SHALL remain stable, and no word SHALL be lost or duplicated.
REQ-023 The buffer SHALL never overflow: occ + inflight <= 2 at every edge.
REQ-024 When rempty==1, r_en SHALL be 0; words already in flight SHALL still be captured.

Reset
REQ-025 While rst==0, r_en SHALL be 0 combinationally.
REQ-026 Reset SHALL asynchronously clear occ, inflight, both buffer entries, m_data, m_valid and rd_count to 0.
REQ-027 A reset asserted mid-operation SHALL discard buffered and in-flight words, and the rdata that follows SHALL be ignored.
REQ-028 After rst deasserts, r_en SHALL first assert no earlier than the next rising edge.

Structure
REQ-029 A shared package fifo_pkg SHALL hold the DATASIZE and CNTSIZE defaults and the constant SKID_DEPTH = 2.
REQ-030 The 2-entry buffer SHALL be a sub-module named stream_skid_buf, with push/pop/occ ports. The top level SHALL hold the r_en logic, inflight and rd_count.

Verification
REQ-031 The bench SHALL pair the block with a synchronous FIFO model that has 1-cycle read latency, and check all output against a queue scoreboard.
REQ-032 Drain: preload 0x00..0x0F, m_ready=1 -> words 0x00..0x0F appear in order on 16 consecutive cycles starting 2 cycles after the first r_en, and rd_count ends at 16.
REQ-033 Backpressure: preload 0x10..0x13, m_ready=0 for 6 cycles then 1 -> r_en pulses exactly twice, m_data holds 0x10 stable, and then 0x10..0x13 are delivered in order.
REQ-034 Alternating ready: preload 0xA0..0xA7, m_ready toggles every cycle -> 8 words are delivered in order with no loss or duplication, and occ never exceeds 2.
REQ-035 Empty: rempty=1 for 10 cycles -> r_en=0 and m_valid=0 throughout; a single write of 0x5A then appears on m_data 2 cycles after r_en.
REQ-036 Mid-operation reset: pull rst low with occ=2 and inflight=1 -> m_valid, r_en and rd_count are 0 immediately, and the next post-reset word comes only from a fresh read.
REQ-037 Wrap: with CNTSIZE=4, deliver 17 words -> rd_count reads 1.
